multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences a shared-memory multicycle MIPS datapath (one memory port for instruction and data, single ALU) for instructions R-type, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI, XORI.
- Drives all datapath enables and mux selects, and handshakes with memory via mem_req/mem_ready.
- Counts retired instructions and traps on illegal opcode or memory timeout.
- Sits beside the register file / ALU / memory in the multicycle top level.

Parameters:
MEM_TIMEOUT, 255, max cycles a memory access waits for mem_ready before trapping (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
op  input  6  opcode, IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag (unused by FSM; branch condition resolved in datapath via pc_write_cond_*)
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access in progress
iord  output  1  0=PC addresses memory, 1=ALUOut
mem_write  output  1  write strobe, qualified by mem_req
ir_write  output  1  load IR
pc_write  output  1  unconditional PC load
pc_write_cond_eq  output  1  PC load if zero
pc_write_cond_ne  output  1  PC load if !zero
pc_source  output  2  0=ALU, 1=ALUOut, 2=jump target
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2
alu_op  output  2  0=add, 1=sub, 2=funct, 3=opcode-defined logic
ext_op  output  1  1=sign extend, 0=zero extend
reg_dst  output  1  1=rd, 0=rt
mem_to_reg  output  1  1=MDR, 0=ALUOut
reg_write  output  1  register file write
trap  output  1  sticky error flag
state_dbg  output  4  current state encoding
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait counter=0, retired=0, trap=0, all FSM outputs at FETCH decode.
- Opcodes: R=6'h00, J=6'h02, BEQ=6'h04, BNE=6'h05, ADDI=6'h08, ANDI=6'h0C, ORI=6'h0D, XORI=6'h0E, LW=6'h23, SW=6'h2B; any other opcode is illegal.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=12.
- All outputs not listed for a state are 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready (the only combinational use of an input).
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0, ext_op=1. Next state:
  - LW/SW -> MEM_ADDR; R -> EXEC_R; BEQ/BNE -> BRANCH; J -> JUMP; ADDI/ANDI/ORI/XORI -> EXEC_I.
  - Illegal opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0, ext_op=1; LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_req=1, iord=1; waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; retire; -> FETCH.
- MEM_WRITE: mem_req=1, iord=1, mem_write=1; waits for mem_ready, then retire and -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2; -> R_WB.
- R_WB: reg_write=1, reg_dst=1; retire; -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2; alu_op=0 for ADDI, 3 for logic ops; ext_op=1 for ADDI, 0 for ANDI/ORI/XORI; -> I_WB.
- I_WB: reg_write=1, reg_dst=0; ext_op and alu_op held as in EXEC_I; retire; -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1.
  - pc_write_cond_eq=(op==BEQ), pc_write_cond_ne=(op==BNE).
  - Retire; -> FETCH.
- JUMP: pc_write=1, pc_source=2; retire; -> FETCH.
- Retire: retired increments by 1 on the cycle leaving the final state; it wraps modulo 2^CNT_W.
- Wait counter:
  - Counts cycles in FETCH/MEM_READ/MEM_WRITE while mem_ready=0.
  - Clears on entry to any state and when mem_ready=1.
  - If it reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP.
  - mem_ready=1 on the same cycle the limit is reached: completion wins, no trap.
- TRAP: all outputs 0, trap=1, absorbing; only reset exits.
- op is sampled only in DECODE, MEM_ADDR, EXEC_I, I_WB and BRANCH; IR is stable there since ir_write=0.
- mem_ready outside memory states is ignored.
- Reset asserted mid-instruction aborts immediately; no retire counted.

Test Plan:
- Reset, mem_ready tied 1, op=6'h00 -> states 0,1,6,7,0; reg_write=1 & reg_dst=1 in state 7 only; retired=1 after 4 cycles.
- op=6'h23, mem_ready=1 -> 0,1,2,3,4; mem_to_reg=1, reg_write=1 in state 4; op=6'h2B -> 0,1,2,5 with mem_write=1 then FETCH; retired=2.
- FETCH with mem_ready low 5 cycles, then high -> mem_req=1 for 6 cycles; ir_write and pc_write pulse once on the 6th cycle.
- op=6'h04 then 6'h05 -> pc_write_cond_eq=1 in first BRANCH, pc_write_cond_ne=1 in second, never both; op=6'h0D -> ext_op=0, alu_op=3; op=6'h08 -> ext_op=1, alu_op=0.
- op=6'h3F -> TRAP (12) after DECODE, trap=1, outputs 0; stays in TRAP until rst_n=0, which gives state=0, trap=0, retired=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in MEM_READ -> TRAP after 4 cycles; repeat with mem_ready=1 on the 4th cycle -> MEM_WB, no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - control FSM for a shared-memory multicycle MIPS datapath
//
// Purpose:
//   Moore FSM that sequences fetch, decode, execute, memory and write-back for
//   R-type, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI and XORI. It drives every
//   datapath enable and mux select, handshakes with the single memory port,
//   counts retired instructions and traps on an illegal opcode or a memory
//   access that waits too long.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   op[5:0]               opcode from IR[31:26], valid from DECODE onward
//   zero                  ALU zero flag (branch is resolved in the datapath)
//   mem_ready             memory completes the current access this cycle
//   mem_req, iord,        memory request, address select, write strobe
//   mem_write
//   ir_write, pc_write,   IR load, unconditional / conditional PC loads
//   pc_write_cond_eq/ne
//   pc_source[1:0]        0=ALU, 1=ALUOut, 2=jump target
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op[1:0]           0=add, 1=sub, 2=funct, 3=opcode-defined logic
//   ext_op                1=sign extend, 0=zero extend
//   reg_dst, mem_to_reg,  register file write port controls
//   reg_write
//   trap                  sticky error flag
//   state_dbg[3:0]        current state encoding
//   retired[CNT_W-1:0]    retired-instruction count (wraps)

module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond_eq,
  output logic             pc_write_cond_ne,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Last wait-counter value that still allows one more stalled cycle; a stall
  // seen while the counter already holds this value is the MEM_TIMEOUT-th one.
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

  // Registered control word. 'fetch' marks the FETCH state so that the only
  // combinational use of mem_ready (IR / PC load) can be gated outside the flops.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       pc_write;
    logic       cond_eq;
    logic       cond_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Control word for a state. op only matters for BRANCH, EXEC_I and I_WB,
  // which are entered from DECODE / EXEC_I where IR is already stable.
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch     = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'd3;
        c.ext_op    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.ext_op    = 1'b1;
      end
      S_MEM_READ: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd1;
        c.pc_source = 2'd1;
        c.cond_eq   = (opc == OP_BEQ);
        c.cond_ne   = (opc == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_op    = (opc == OP_ADDI) ? 2'd0 : 2'd3;
        c.ext_op    = (opc == OP_ADDI);
      end
      S_I_WB: begin
        // ALU keeps producing the immediate result while it is written back.
        c.reg_write = 1'b1;
        c.alu_op    = (opc == OP_ADDI) ? 2'd0 : 2'd3;
        c.ext_op    = (opc == OP_ADDI);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q;
  logic             retire;
  ctrl_t            ctrl_q;

  // Branch outcome is resolved in the datapath through pc_write_cond_*.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)                state_d = S_DECODE;
        else if (wait_q == WAIT_LIMIT) state_d = S_TRAP;
        else                          wait_d  = wait_q + 16'd1;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_d = S_MEM_ADDR;
          OP_R:                                state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_J:                                state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:   state_d = S_EXEC_I;
          default:                             state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (op == OP_LW)      state_d = S_MEM_READ;
        else if (op == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_TRAP;
      end
      S_MEM_READ: begin
        if (mem_ready)                state_d = S_MEM_WB;
        else if (wait_q == WAIT_LIMIT) state_d = S_TRAP;
        else                          wait_d  = wait_q + 16'd1;
      end
      S_MEM_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_EXEC_R: state_d = S_R_WB;
      S_R_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH, S_JUMP, S_I_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: state_d = S_I_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    // Every access starts with a fresh budget, and a completed handshake resets it.
    if (state_d != state_q || mem_ready) wait_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      ctrl_q    <= decode_ctrl(S_FETCH, OP_R);
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_q + CNT_W'(retire);
      trap_q    <= (state_d == S_TRAP);
      ctrl_q    <= decode_ctrl(state_d, op);
    end
  end

  assign mem_req          = ctrl_q.mem_req;
  assign iord             = ctrl_q.iord;
  assign mem_write        = ctrl_q.mem_write;
  assign ir_write         = ctrl_q.fetch & mem_ready;
  assign pc_write         = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign pc_write_cond_eq = ctrl_q.cond_eq;
  assign pc_write_cond_ne = ctrl_q.cond_ne;
  assign pc_source        = ctrl_q.pc_source;
  assign alu_src_a        = ctrl_q.alu_src_a;
  assign alu_src_b        = ctrl_q.alu_src_b;
  assign alu_op           = ctrl_q.alu_op;
  assign ext_op           = ctrl_q.ext_op;
  assign reg_dst          = ctrl_q.reg_dst;
  assign mem_to_reg       = ctrl_q.mem_to_reg;
  assign reg_write        = ctrl_q.reg_write;
  assign trap             = trap_q;
  assign state_dbg        = state_q;
  assign retired          = retired_q;

endmodule
